// File: rtl/hamming_flit_packetizer_pkg.sv
// Shared types and constants for the Hamming flit packetizer.
// Holds the Hamming(7,4) encoder used at FIFO write time.
package noc_pkg;

  localparam int FLIT_W   = 8;
  localparam int ADDR_W   = 7;
  localparam int NIBBLE_W = 4;
  localparam int CW_W     = 7;
  localparam int ENTRY_W  = ADDR_W + CW_W;

  localparam logic HEAD_BIT = 1'b1;
  localparam logic BODY_BIT = 1'b0;

  typedef enum logic {
    HEAD = 1'b0,
    BODY = 1'b1
  } ser_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [CW_W-1:0]   cw;
  } entry_t;

  // cw[0] is Hamming position 1; data sits at positions 3,5,6,7
  function automatic logic [CW_W-1:0] hamming74_encode(
    input logic [NIBBLE_W-1:0] nibble
  );
    logic p1;
    logic p2;
    logic p3;
    p1 = nibble[0] ^ nibble[1] ^ nibble[3];
    p2 = nibble[0] ^ nibble[2] ^ nibble[3];
    p3 = nibble[1] ^ nibble[2] ^ nibble[3];
    return {nibble[3], nibble[2], nibble[1], p3,
            nibble[0], p2, p1};
  endfunction

endpackage

// File: rtl/hamming_flit_packetizer_if.sv
// Input nibble handshake and output flit handshake.
// slave faces the packetizer; master faces the driver.
interface hamming_flit_packetizer_if;
  import noc_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [NIBBLE_W-1:0] in_data;
  logic [ADDR_W-1:0]   in_addr;
  logic                flit_valid;
  logic                flit_ready;
  logic [FLIT_W-1:0]   flit_out;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_addr,
    output in_ready,
    output flit_valid,
    output flit_out,
    input  flit_ready
  );

  modport master (
    output in_valid,
    output in_data,
    output in_addr,
    input  in_ready,
    input  flit_valid,
    input  flit_out,
    output flit_ready
  );

endinterface

// File: rtl/hamming_flit_packetizer_fifo.sv
// Synchronous FIFO with occupancy count.
// Push at full and pop at empty are ignored.
module noc_sync_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CAP);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  // Storage carries no reset; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hamming_flit_packetizer.sv
// Encodes nibbles, queues them, and emits head/body flit pairs.
// Outputs are driven only from registered state.
module hamming_flit_packetizer
  import noc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  hamming_flit_packetizer_if.slave bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]       pkt_count
);

  entry_t            wr_entry;
  entry_t            rd_entry;
  logic [ENTRY_W-1:0] rd_raw;
  ser_state_t        state;
  ser_state_t        state_nx;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [FLIT_W-1:0] flit;

  assign wr_entry.addr = bus.in_addr;
  assign wr_entry.cw   = hamming74_encode(bus.in_data);
  assign rd_entry      = entry_t'(rd_raw);

  // Full blocks intake even when a pop lands in the same cycle
  assign bus.in_ready   = !full;
  assign push           = bus.in_valid && !full;
  assign bus.flit_valid = !empty;
  assign bus.flit_out   = flit;

  noc_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_raw),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    flit     = {HEAD_BIT, rd_entry.addr};
    unique case (state)
      HEAD: begin
        if (!empty && bus.flit_ready) begin
          state_nx = BODY;
        end
      end
      BODY: begin
        flit = {BODY_BIT, rd_entry.cw};
        if (!empty && bus.flit_ready) begin
          pop      = 1'b1;
          state_nx = HEAD;
        end
      end
      default: state_nx = HEAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HEAD;
      pkt_count <= '0;
    end else begin
      state <= state_nx;
      if (pop) begin
        pkt_count <= pkt_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hamming_flit_packetizer.sv
// Scoreboard bench: driver queues expected flits, monitor compares.
// Reference encoder works from Hamming position parity rules.
module tb_hamming_flit_packetizer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CW-1:0]    fifo_count;
  logic [CNT_W-1:0] pkt_count;

  int checks = 0;
  int failures = 0;
  int mdl_cnt = 0;
  int mdl_pkt = 0;
  logic [7:0] exp_q[$];

  hamming_flit_packetizer_if ifc ();

  hamming_flit_packetizer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (ifc.slave),
    .fifo_count (fifo_count),
    .pkt_count  (pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Parity bit at position 2^i covers every position with bit i set
  function automatic logic [6:0] ref_cw(input logic [3:0] d);
    logic [7:0] pos;
    int dp[4];
    logic par;
    dp = '{3, 5, 6, 7};
    pos = '0;
    for (int k = 0; k < 4; k++) pos[dp[k]] = d[k];
    for (int i = 0; i < 3; i++) begin
      par = 1'b0;
      for (int p = 1; p <= 7; p++)
        if (((p >> i) & 1) == 1 && p != (1 << i)) par ^= pos[p];
      pos[1 << i] = par;
    end
    return pos[7:1];
  endfunction

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      mdl_cnt = 0;
      mdl_pkt = 0;
    end else begin
      automatic bit rdy = (mdl_cnt < DEPTH);
      chk("fifo_count", int'(fifo_count), mdl_cnt);
      chk("in_ready", int'(ifc.in_ready), int'(rdy));
      chk("flit_valid", int'(ifc.flit_valid), int'(mdl_cnt != 0));
      chk("pkt_count", int'(pkt_count), mdl_pkt % (1 << CNT_W));
      if (mdl_cnt != 0) begin
        if (exp_q.size() == 0) begin
          chk("flit_queue_empty", 1, 0);
        end else begin
          chk("flit_out", int'(ifc.flit_out), int'(exp_q[0]));
          if (ifc.flit_ready) begin
            if (exp_q[0][7] == 1'b0) begin
              mdl_pkt++;
              mdl_cnt--;
            end
            void'(exp_q.pop_front());
          end
        end
      end
      if (ifc.in_valid && rdy) begin
        exp_q.push_back({1'b1, ifc.in_addr});
        exp_q.push_back({1'b0, ref_cw(ifc.in_data)});
        mdl_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input logic [6:0] a);
    int n;
    n = 0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    ifc.in_addr  = a;
    @(negedge clk);
    while (!ifc.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 1, 0);
    tick();
    ifc.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while (fifo_count != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 1, 0);
    tick();
  endtask

  initial begin
    logic [6:0] a0;
    int acc;
    bit rdone;
    ifc.in_valid   = 1'b0;
    ifc.in_data    = '0;
    ifc.in_addr    = '0;
    ifc.flit_ready = 1'b0;
    #3;
    chk("rst_in_ready", int'(ifc.in_ready), 1);
    chk("rst_flit_valid", int'(ifc.flit_valid), 0);
    chk("rst_fifo_count", int'(fifo_count), 0);
    chk("rst_pkt_count", int'(pkt_count), 0);
    #20;
    rst_n = 1'b1;
    tick();

    ifc.flit_ready = 1'b1;
    send(4'b1011, 7'h2A);
    chk("lat_head_valid", int'(ifc.flit_valid), 1);
    chk("lat_head", int'(ifc.flit_out), 8'hAA);
    tick();
    chk("lat_body", int'(ifc.flit_out), 8'h55);
    tick();
    chk("single_pkt_count", int'(pkt_count), 1);
    chk("single_fifo_count", int'(fifo_count), 0);

    for (int n = 0; n < 16; n++) send(4'(n), 7'($urandom));
    drain();

    ifc.flit_ready = 1'b0;
    acc = 0;
    a0 = 7'($urandom);
    for (int i = 0; i < 6; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data  = 4'($urandom);
      ifc.in_addr  = (i == 0) ? a0 : 7'($urandom);
      @(negedge clk);
      if (ifc.in_ready) acc++;
      tick();
    end
    ifc.in_valid = 1'b0;
    chk("bp_accepts", acc, 4);
    chk("bp_fifo_full", int'(fifo_count), 4);
    chk("bp_in_ready", int'(ifc.in_ready), 0);
    chk("bp_hold_head", int'(ifc.flit_out), int'({1'b1, a0}));
    ifc.flit_ready = 1'b1;
    tick();
    chk("bp_ready_after_head", int'(ifc.in_ready), 0);
    tick();
    chk("bp_ready_after_pop", int'(ifc.in_ready), 1);
    chk("bp_count_after_pop", int'(fifo_count), 3);
    drain();

    ifc.flit_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4'($urandom), 7'($urandom));
    ifc.in_valid   = 1'b1;
    ifc.in_data    = 4'($urandom);
    ifc.in_addr    = 7'($urandom);
    ifc.flit_ready = 1'b1;
    tick();
    chk("fp_head_count", int'(fifo_count), 4);
    chk("fp_head_ready", int'(ifc.in_ready), 0);
    tick();
    chk("fp_pop_count", int'(fifo_count), 3);
    chk("fp_pop_ready", int'(ifc.in_ready), 1);
    tick();
    chk("fp_push_next", int'(fifo_count), 4);
    ifc.in_valid = 1'b0;
    drain();

    rdone = 1'b0;
    fork
      begin
        repeat (60) begin
          repeat ($urandom_range(0, 2)) tick();
          send(4'($urandom), 7'($urandom));
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          ifc.flit_ready = 1'($urandom);
          tick();
        end
      end
    join
    ifc.flit_ready = 1'b1;
    drain();

    ifc.flit_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(4'($urandom), 7'($urandom));
    ifc.flit_ready = 1'b1;
    tick();
    ifc.flit_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_flit_valid", int'(ifc.flit_valid), 0);
    chk("midrst_fifo_count", int'(fifo_count), 0);
    chk("midrst_pkt_count", int'(pkt_count), 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    ifc.flit_ready = 1'b1;
    send(4'($urandom), 7'($urandom));
    chk("midrst_next_valid", int'(ifc.flit_valid), 1);
    chk("midrst_next_head", int'(ifc.flit_out[7]), 1);
    for (int i = 0; i < 16; i++) send(4'($urandom), 7'($urandom));
    drain();
    chk("wrap_pkt_count", int'(pkt_count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
